stk_engine: RTL and testbench
=============================

Name: stk_engine

Overview:
- Parametrised LIFO stack engine: the successor to the fixed PUSH/POP stack.
- Generalised in data width and depth; adds a NOP and an atomic REPLACE (pop then push) opcode, flush, occupancy reporting and per-command error reporting.
- Sits behind a valid/ready command port and drives a one-deep registered response port with backpressure.

Parameters:
- W, 32, data width in bits.
- N, 16, stack depth in entries; N >= 2.
- CW, $clog2(N+1), occupancy width; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  empty the stack; takes effect at the next edge.
- cmd_vld  in  1  command valid.
- cmd_op  in  2  stk_pkg::opcode_t.
- cmd_dat  in  W  push data; used by PUSH and REPLACE.
- cmd_rdy  out  1  command accept.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response accept.
- rsp_dat  out  W  popped data; 0 when not applicable.
- rsp_err  out  1  command failed (overflow or underflow).
- occ  out  CW  current entry count.
- empty  out  1  occ == 0.
- full  out  1  occ == N.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: occ=0, empty=1, full=0, rsp_vld=0, rsp_dat=0, rsp_err=0, cmd_rdy=1 from the first cycle after reset. Storage contents are not reset.
- Acceptance: cmd_rdy = !flush && (!rsp_vld || rsp_rdy). A command is accepted when cmd_vld && cmd_rdy.
- Every accepted command, including NOP, produces exactly one response. The response is registered and appears on rsp_vld the cycle after acceptance (latency 1).
- rsp_vld/rsp_dat/rsp_err hold until rsp_rdy. Back-to-back throughput is 1/cycle while rsp_rdy=1.
- NOP (00): no state change; rsp_dat=0, rsp_err=0.
- PUSH (01):
  - If !full: mem[occ]=cmd_dat, occ+1; rsp_dat=0, rsp_err=0.
  - If full: data dropped, occ unchanged, rsp_err=1.
- POP (10):
  - If !empty: rsp_dat=mem[occ-1], occ-1, rsp_err=0.
  - If empty: rsp_dat=0, rsp_err=1, occ unchanged.
- REPLACE (11):
  - If !empty: rsp_dat=mem[occ-1], then mem[occ-1]=cmd_dat; occ unchanged; rsp_err=0. Allowed when full.
  - If empty: no write, rsp_dat=0, rsp_err=1.
- Data path and updates:
  - The top read is combinational from storage at index occ-1 and is captured into rsp_dat at acceptance.
  - No bypass is needed: one command per cycle, and state updates at the same edge as response capture.
  - occ, empty and full update at the edge of acceptance. Commands in consecutive cycles see the updated state.
- Flush:
  - When asserted: occ becomes 0 at the next edge and cmd_rdy=0 during that cycle.
  - A pending response is unaffected and is still delivered.
  - Flush and rst both asserted: rst wins.
- Reset mid-operation: a pending response is discarded (rsp_vld=0), occ=0.
- Width rules:
  - occ arithmetic is unsigned CW bits; the index is occ-1 truncated to $clog2(N) bits and is used only when !empty.
  - Neither wrap-around nor saturation is possible, because of the full/empty guards.
- Assertions:
  - occ <= N at all times.
  - cmd_op known whenever cmd_vld=1.
  - rsp_* stable while rsp_vld && !rsp_rdy.

Decomposition:
- stk_pkg:
  - Extend opcode_t to OPCODE_NOP=2'b00, OPCODE_PUSH=2'b01, OPCODE_POP=2'b10, OPCODE_REPLACE=2'b11. The existing PUSH/POP encodings are preserved.
  - Add typedef struct rsp_t {dat, err}; it is parametrised by W at the use site, or the package holds W-independent fields only.
- Sub-module stk_engine_mem (parameters W, N):
  - Flop array, one write port (we, waddr, wdat), one asynchronous read port (raddr, rdat).
  - Keeps storage swappable for an SRAM macro later. The engine holds the occupancy counter and response register.

Test Plan (W=8, N=4, rsp_rdy=1 unless stated):
- Basic LIFO: PUSH 0x11,0x22,0x33 then POP x3 -> rsp_dat 0x33,0x22,0x11, all rsp_err=0; occ 3->0; empty=1 at end.
- Full/overflow: PUSH 0xA0..0xA3 (full=1, occ=4), PUSH 0xFF -> rsp_err=1, occ stays 4; POP -> 0xA3.
- Underflow and REPLACE on empty: POP on empty -> rsp_dat=0, rsp_err=1; REPLACE 0x55 on empty -> rsp_err=1, occ=0.
- REPLACE when full: stack 0x01..0x04 (full), REPLACE 0x99 -> rsp_dat=0x04, occ=4; POP -> 0x99.
- Backpressure: hold rsp_rdy=0 after one PUSH -> cmd_rdy=0, rsp_vld stays 1 and stable for 5 cycles; release -> next command accepted the same cycle rsp_rdy=1.
- Flush and reset: occ=3 with pending POP response and rsp_rdy=0, assert flush 1 cycle -> occ=0, the response (top value) is still delivered; repeat with rst -> rsp_vld=0, occ=0, cmd_rdy=1 the next cycle.

Source files
------------

// File: rtl/stk_pkg.sv
// Shared types for the LIFO stack engine.
// Opcode encodings keep the original PUSH/POP values.
package stk_pkg;

  typedef enum logic [1:0] {
    OPCODE_NOP     = 2'b00,
    OPCODE_PUSH    = 2'b01,
    OPCODE_POP     = 2'b10,
    OPCODE_REPLACE = 2'b11
  } opcode_t;

endpackage

// File: rtl/stk_engine_mem.sv
// Stack storage: flop array, one write port, async read.
// Kept separate so an SRAM macro can drop in later.
module stk_engine_mem #(
  parameter int W = 32,
  parameter int N = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdat
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/stk_engine.sv
// LIFO stack engine with valid/ready command port and
// a one-deep registered response port.
module stk_engine
  import stk_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 16,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cmd_vld,
  input  opcode_t       cmd_op,
  input  logic [W-1:0]  cmd_dat,
  output logic          cmd_rdy,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [W-1:0]  rsp_dat,
  output logic          rsp_err,
  output logic [CW-1:0] occ,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(N);

  typedef struct packed {
    logic [W-1:0] dat;
    logic         err;
  } rsp_t;

  rsp_t          rsp_q;
  rsp_t          rsp_n;
  logic [CW-1:0] occ_n;
  logic          acc;
  logic          wr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] idx;
  logic [W-1:0]  rdat;

  assign empty   = (occ == '0);
  assign full    = (occ == CW'(N));
  assign cmd_rdy = !flush && (!rsp_vld || rsp_rdy);
  assign acc     = cmd_vld && cmd_rdy;
  assign idx     = AW'(occ - CW'(1));
  assign we      = acc && wr;
  assign rsp_dat = rsp_q.dat;
  assign rsp_err = rsp_q.err;

  always_comb begin
    rsp_n = '0;
    occ_n = occ;
    wr    = 1'b0;
    waddr = AW'(occ);
    unique case (cmd_op)
      OPCODE_PUSH: begin
        if (full) begin
          rsp_n.err = 1'b1;
        end else begin
          wr    = 1'b1;
          occ_n = occ + CW'(1);
        end
      end
      OPCODE_POP: begin
        if (empty) begin
          rsp_n.err = 1'b1;
        end else begin
          rsp_n.dat = rdat;
          occ_n     = occ - CW'(1);
        end
      end
      OPCODE_REPLACE: begin
        if (empty) begin
          rsp_n.err = 1'b1;
        end else begin
          rsp_n.dat = rdat;
          wr        = 1'b1;
          waddr     = idx;
        end
      end
      default: ;
    endcase
  end

  // Flush blocks acceptance, so it never races a command update.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= '0;
      rsp_vld <= 1'b0;
      rsp_q   <= '0;
    end else begin
      if (flush) begin
        occ <= '0;
      end else if (acc) begin
        occ <= occ_n;
      end
      if (acc) begin
        rsp_vld <= 1'b1;
        rsp_q   <= rsp_n;
      end else if (rsp_rdy) begin
        rsp_vld <= 1'b0;
        rsp_q   <= '0;
      end
    end
  end

  stk_engine_mem #(
    .W(W),
    .N(N)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdat (cmd_dat),
    .raddr(idx),
    .rdat (rdat)
  );

  a_occ_max: assert property (@(posedge clk) occ <= CW'(N));

  a_op_known: assert property (
    @(posedge clk) disable iff (rst)
    cmd_vld |-> !$isunknown(cmd_op));

  a_rsp_hold: assert property (
    @(posedge clk) disable iff (rst)
    rsp_vld && !rsp_rdy |=>
      rsp_vld && $stable(rsp_dat) && $stable(rsp_err));

endmodule

// File: tb/tb_stk_engine.sv
// Self-checking bench for stk_engine against a queue-based
// LIFO reference model.
module tb_stk_engine;
  import stk_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          cmd_vld = 1'b0;
  opcode_t       cmd_op = OPCODE_NOP;
  logic [W-1:0]  cmd_dat = '0;
  logic          cmd_rdy;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b1;
  logic [W-1:0]  rsp_dat;
  logic          rsp_err;
  logic [CW-1:0] occ;
  logic          empty;
  logic          full;

  int vec  = 0;
  int errs = 0;

  logic [W-1:0] stk[$];
  bit           m_vld = 1'b0;
  logic [W-1:0] m_dat = '0;
  bit           m_err = 1'b0;

  stk_engine #(.W(W), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .cmd_vld(cmd_vld),
    .cmd_op (cmd_op),
    .cmd_dat(cmd_dat),
    .cmd_rdy(cmd_rdy),
    .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy),
    .rsp_dat(rsp_dat),
    .rsp_err(rsp_err),
    .occ    (occ),
    .empty  (empty),
    .full   (full)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input bit v, input opcode_t op,
                     input logic [W-1:0] d, input bit rdy,
                     input bit fl);
    bit exp_rdy;
    bit acc;
    cmd_vld = v;
    cmd_op  = op;
    cmd_dat = d;
    rsp_rdy = rdy;
    flush   = fl;
    #4;
    exp_rdy = !fl && (!m_vld || rdy);
    vec++;
    if (cmd_rdy !== exp_rdy) begin
      errs++;
      $display("FAIL cmd_rdy t=%0t: got %b expected %b",
               $time, cmd_rdy, exp_rdy);
    end
    acc = v && exp_rdy;
    if (m_vld && rdy) m_vld = 1'b0;
    if (fl) begin
      stk.delete();
    end else if (acc) begin
      m_vld = 1'b1;
      m_dat = '0;
      m_err = 1'b0;
      case (op)
        OPCODE_PUSH:
          if (stk.size() < N) stk.push_back(d);
          else m_err = 1'b1;
        OPCODE_POP:
          if (stk.size() > 0) m_dat = stk.pop_back();
          else m_err = 1'b1;
        OPCODE_REPLACE:
          if (stk.size() > 0) begin
            m_dat = stk[stk.size()-1];
            stk[stk.size()-1] = d;
          end else m_err = 1'b1;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    vec++;
    if (rsp_vld !== m_vld) begin
      errs++;
      $display("FAIL rsp_vld t=%0t: got %b expected %b",
               $time, rsp_vld, m_vld);
    end
    if (m_vld) begin
      vec++;
      if (rsp_dat !== m_dat || rsp_err !== m_err) begin
        errs++;
        $display("FAIL rsp t=%0t: got dat=%h err=%b expected dat=%h err=%b",
                 $time, rsp_dat, rsp_err, m_dat, m_err);
      end
    end
    vec++;
    if (occ !== CW'(stk.size()) || empty !== (stk.size() == 0) ||
        full !== (stk.size() == N)) begin
      errs++;
      $display("FAIL occ t=%0t: got occ=%0d e=%b f=%b expected occ=%0d",
               $time, occ, empty, full, stk.size());
    end
  endtask

  task automatic test_reset(input bit fl);
    rst     = 1'b1;
    flush   = fl;
    cmd_vld = 1'b1;
    cmd_op  = OPCODE_PUSH;
    rsp_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    flush   = 1'b0;
    cmd_vld = 1'b0;
    rsp_rdy = 1'b1;
    stk.delete();
    m_vld = 1'b0;
    vec++;
    if (rsp_vld !== 1'b0 || rsp_dat !== '0 || rsp_err !== 1'b0 ||
        occ !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errs++;
      $display("FAIL reset: got vld=%b dat=%h err=%b occ=%0d e=%b f=%b expected 0 00 0 0 1 0",
               rsp_vld, rsp_dat, rsp_err, occ, empty, full);
    end
    #4;
    vec++;
    if (cmd_rdy !== 1'b1) begin
      errs++;
      $display("FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lifo();
    logic [W-1:0] e [3] = '{8'h33, 8'h22, 8'h11};
    cyc(1, OPCODE_PUSH, 8'h11, 1, 0);
    cyc(1, OPCODE_PUSH, 8'h22, 1, 0);
    cyc(1, OPCODE_PUSH, 8'h33, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, OPCODE_POP, 8'h00, 1, 0);
      vec++;
      if (rsp_dat !== e[i] || rsp_err !== 1'b0) begin
        errs++;
        $display("FAIL lifo_pop%0d: got %h/%b expected %h/0",
                 i, rsp_dat, rsp_err, e[i]);
      end
    end
    vec++;
    if (empty !== 1'b1) begin
      errs++;
      $display("FAIL lifo_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++)
      cyc(1, OPCODE_PUSH, 8'hA0 + W'(i), 1, 0);
    vec++;
    if (full !== 1'b1 || occ !== CW'(4)) begin
      errs++;
      $display("FAIL ovf_full: got f=%b occ=%0d expected 1 4", full, occ);
    end
    cyc(1, OPCODE_PUSH, 8'hFF, 1, 0);
    vec++;
    if (rsp_err !== 1'b1 || occ !== CW'(4)) begin
      errs++;
      $display("FAIL ovf_err: got err=%b occ=%0d expected 1 4", rsp_err, occ);
    end
    cyc(1, OPCODE_POP, 8'h00, 1, 0);
    vec++;
    if (rsp_dat !== 8'hA3) begin
      errs++;
      $display("FAIL ovf_pop: got %h expected a3", rsp_dat);
    end
  endtask

  task automatic test_underflow();
    test_reset(0);
    cyc(1, OPCODE_POP, 8'h00, 1, 0);
    vec++;
    if (rsp_dat !== '0 || rsp_err !== 1'b1) begin
      errs++;
      $display("FAIL udf_pop: got %h/%b expected 00/1", rsp_dat, rsp_err);
    end
    cyc(1, OPCODE_REPLACE, 8'h55, 1, 0);
    vec++;
    if (rsp_err !== 1'b1 || occ !== '0) begin
      errs++;
      $display("FAIL udf_rep: got err=%b occ=%0d expected 1 0", rsp_err, occ);
    end
    cyc(1, OPCODE_NOP, 8'h77, 1, 0);
  endtask

  task automatic test_replace_full();
    test_reset(0);
    for (int i = 1; i <= 4; i++)
      cyc(1, OPCODE_PUSH, W'(i), 1, 0);
    cyc(1, OPCODE_REPLACE, 8'h99, 1, 0);
    vec++;
    if (rsp_dat !== 8'h04 || rsp_err !== 1'b0 || occ !== CW'(4)) begin
      errs++;
      $display("FAIL rep_full: got %h/%b occ=%0d expected 04/0 4",
               rsp_dat, rsp_err, occ);
    end
    cyc(1, OPCODE_POP, 8'h00, 1, 0);
    vec++;
    if (rsp_dat !== 8'h99) begin
      errs++;
      $display("FAIL rep_pop: got %h expected 99", rsp_dat);
    end
  endtask

  task automatic test_backpressure();
    test_reset(0);
    cyc(1, OPCODE_PUSH, 8'h5A, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, OPCODE_POP, 8'h00, 0, 0);
      vec++;
      if (rsp_vld !== 1'b1 || rsp_dat !== '0 || occ !== CW'(1)) begin
        errs++;
        $display("FAIL bp_hold%0d: got vld=%b dat=%h occ=%0d expected 1 00 1",
                 i, rsp_vld, rsp_dat, occ);
      end
    end
    cyc(1, OPCODE_POP, 8'h00, 1, 0);
    vec++;
    if (rsp_dat !== 8'h5A || occ !== '0) begin
      errs++;
      $display("FAIL bp_release: got %h occ=%0d expected 5a 0", rsp_dat, occ);
    end
    cyc(0, OPCODE_NOP, 8'h00, 1, 0);
  endtask

  task automatic test_flush_reset();
    test_reset(0);
    for (int i = 0; i < 4; i++)
      cyc(1, OPCODE_PUSH, 8'hC0 + W'(i), 1, 0);
    cyc(1, OPCODE_POP, 8'h00, 1, 0);
    cyc(1, OPCODE_NOP, 8'h00, 0, 1);
    vec++;
    if (occ !== '0 || rsp_vld !== 1'b1 || rsp_dat !== 8'hC3) begin
      errs++;
      $display("FAIL flush: got occ=%0d vld=%b dat=%h expected 0 1 c3",
               occ, rsp_vld, rsp_dat);
    end
    cyc(0, OPCODE_NOP, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, OPCODE_PUSH, 8'hD0 + W'(i), 1, 0);
    cyc(1, OPCODE_POP, 8'h00, 1, 0);
    cyc(0, OPCODE_NOP, 8'h00, 0, 0);
    test_reset(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 4) != 0,
          opcode_t'($urandom_range(0, 3)),
          W'($urandom),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 24) == 0);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset(0);
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace_full();
    test_backpressure();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
